// File: rtl/pipe_ctrl_n_pkg.sv
// pipe_ctrl_n_pkg
//   Shared definitions for the pipeline stall/flush controller:
//   ERET cause code, default exception vector, FSM state encoding and a
//   counter-width helper.
package pipe_ctrl_n_pkg;

    // Cause code that selects an EPC return instead of the exception vector.
    localparam logic [31:0] EXC_ERET        = 32'h0000_000E;
    localparam logic [31:0] EXC_VECTOR_DFLT = 32'hBFC0_0380;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_REDIRECT = 1'b1
    } ctrl_state_t;

    // Width of a down-counter that must hold values 0 .. n-1 (at least 1 bit).
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pipe_ctrl_n_stall_therm_enc.sv
// stall_therm_enc
//   Priority-to-thermometer encoder: the highest set request bit k produces
//   a mask with bits 0..k set and everything above clear. A stage that asks
//   to stall freezes itself and every stage upstream of it.
// Ports
//   req   in  WIDTH  per-stage stall requests (bit 0 = pc stage)
//   mask  out WIDTH  thermometer stall mask
module stall_therm_enc #(
    parameter int WIDTH = 7
) (
    input  logic [WIDTH-1:0] req,
    output logic [WIDTH-1:0] mask
);

    always_comb begin
        logic any_above;
        any_above = 1'b0;
        mask      = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            any_above = any_above | req[i];
            mask[i]   = any_above;
        end
    end

endmodule

// File: rtl/pipe_ctrl_n.sv
// pipe_ctrl_n
//   Stall/flush controller for an N-stage in-order pipeline. Decodes
//   per-stage stall requests into a thermometer stall bus and sequences
//   exception / ERET redirects: flush and new_pc are asserted for
//   FLUSH_CYCLES cycles starting one cycle after the exception commits.
//
//   Optional macro PIPE_CTRL_WDOG_EN adds a stall watchdog: WDOG_LIMIT
//   consecutive cycles of stall[0] force a redirect to EXC_VECTOR and set
//   the sticky wdog_err flag. Without the macro wdog_err is tied low.
//
// Ports
//   clk           in   1           clock, rising edge
//   rst           in   1           asynchronous active-low reset
//   stallreq      in   NUM_STAGES  per-stage stall request
//   exc_valid_i   in   1           exception/ERET commits this cycle
//   excepttype_i  in   EXC_W       cause code (EXC_ERET = return via epc)
//   cp0_epc_i     in   ADDR_W      ERET return address
//   stall         out  NUM_STAGES  thermometer stall bus
//   flush         out  1           flush all stage registers
//   new_pc        out  ADDR_W      redirect target while flush=1, else 0
//   busy          out  1           controller not idle
//   wdog_err      out  1           sticky watchdog error
//
// state       | meaning
// ST_IDLE     | normal operation, stall bus follows stallreq
// ST_REDIRECT | flush/new_pc asserted, stalls suppressed, flush_cnt running
module pipe_ctrl_n
    import pipe_ctrl_n_pkg::*;
#(
    parameter int                NUM_STAGES   = 7,
    parameter int                ADDR_W       = 32,
    parameter int                EXC_W        = 32,
    parameter int                FLUSH_CYCLES = 1,
    parameter logic [ADDR_W-1:0] EXC_VECTOR   = ADDR_W'(EXC_VECTOR_DFLT),
    parameter int                WDOG_LIMIT   = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_STAGES-1:0] stallreq,
    input  logic                  exc_valid_i,
    input  logic [EXC_W-1:0]      excepttype_i,
    input  logic [ADDR_W-1:0]     cp0_epc_i,
    output logic [NUM_STAGES-1:0] stall,
    output logic                  flush,
    output logic [ADDR_W-1:0]     new_pc,
    output logic                  busy,
    output logic                  wdog_err
);

    localparam int             CNT_W    = cnt_width(FLUSH_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_CYCLES - 1);

    if (FLUSH_CYCLES < 1) begin : g_bad_flush_cycles
        $error("pipe_ctrl_n: FLUSH_CYCLES must be >= 1");
    end
    if (WDOG_LIMIT < 1) begin : g_bad_wdog_limit
        $error("pipe_ctrl_n: WDOG_LIMIT must be >= 1");
    end

    ctrl_state_t           state_q, state_d;
    logic [CNT_W-1:0]      flush_cnt_q, flush_cnt_d;
    logic [ADDR_W-1:0]     target_q, target_d;
    logic [NUM_STAGES-1:0] stall_mask;
    logic                  wdog_trip;

    stall_therm_enc #(
        .WIDTH (NUM_STAGES)
    ) u_stall_therm_enc (
        .req  (stallreq),
        .mask (stall_mask)
    );

    // Flush beats stall; reset is also folded in so the bus reads 0 while
    // rst is held, independent of stallreq.
    assign stall  = (rst && (state_q == ST_IDLE)) ? stall_mask : '0;
    assign flush  = (state_q == ST_REDIRECT);
    assign new_pc = flush ? target_q : '0;
    assign busy   = (state_q != ST_IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            flush_cnt_q <= '0;
            target_q    <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            target_q    <= target_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        target_d    = target_q;
        case (state_q)
            ST_IDLE: begin
                if (exc_valid_i || wdog_trip) begin
                    state_d     = ST_REDIRECT;
                    flush_cnt_d = CNT_LOAD;
                    // A real exception owns the target; a watchdog-only
                    // trip always goes to the vector.
                    if (exc_valid_i && (excepttype_i == EXC_W'(EXC_ERET)))
                        target_d = cp0_epc_i;
                    else
                        target_d = EXC_VECTOR;
                end
            end
            ST_REDIRECT: begin
                // exc_valid_i is deliberately ignored here: no extension,
                // no retarget.
                if (flush_cnt_q == '0) begin
                    state_d  = ST_IDLE;
                    target_d = '0;
                end else begin
                    flush_cnt_d = flush_cnt_q - 1'b1;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                flush_cnt_d = '0;
                target_d    = '0;
            end
        endcase
    end

`ifdef PIPE_CTRL_WDOG_EN
    localparam int              LEN_W    = $clog2(WDOG_LIMIT + 1);
    localparam logic [LEN_W-1:0] LEN_MAX  = '1;
    localparam logic [LEN_W-1:0] LEN_TRIP = LEN_W'(WDOG_LIMIT - 1);

    logic [LEN_W-1:0] stall_len_q;
    logic             wdog_err_q;

    // Trip on the cycle that is the WDOG_LIMIT-th consecutive stall[0]
    // cycle, so the redirect lands on the following edge like an exception.
    assign wdog_trip = (state_q == ST_IDLE) && stall[0] && (stall_len_q >= LEN_TRIP);
    assign wdog_err  = wdog_err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_len_q <= '0;
            wdog_err_q  <= 1'b0;
        end else begin
            if (!stall[0] || flush)
                stall_len_q <= '0;
            else if (stall_len_q != LEN_MAX)
                stall_len_q <= stall_len_q + 1'b1;
            if (wdog_trip)
                wdog_err_q <= 1'b1;
        end
    end
`else
    assign wdog_trip = 1'b0;
    assign wdog_err  = 1'b0;
`endif

endmodule
